// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the APB interrupt controller: register offsets,
// FSM state encoding and default field widths.
package irq_ctrl_pkg;

    localparam int DEFAULT_PRIO_W = 3;
    localparam int DEFAULT_ID_W   = 5;

    localparam logic [7:0] REG_ENABLE    = 8'h00;
    localparam logic [7:0] REG_MODE      = 8'h01;
    localparam logic [7:0] REG_PENDING   = 8'h02;
    localparam logic [7:0] REG_ACTIVE    = 8'h03;
    localparam logic [7:0] REG_ACK       = 8'h04;
    localparam logic [7:0] REG_GLOBAL_EN = 8'h05;
    localparam logic [7:0] REG_PRIO_BASE = 8'h10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_GAP   = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_arbiter.sv
// Combinational priority selector: highest priority wins, ties resolve to
// the lowest index. A priority of zero is still a valid contender.
module irq_prio_arbiter #(
    parameter int NUM_IRQ = 8,
    parameter int PRIO_W  = 3,
    parameter int ID_W    = 5
) (
    input  logic [NUM_IRQ-1:0]             valid_i,
    input  logic [NUM_IRQ-1:0][PRIO_W-1:0] prio_i,
    output logic [ID_W-1:0]                id_o,
    output logic                           any_valid_o
);

    logic [PRIO_W-1:0] best;

    // Ascending scan with strict '>' keeps the lower index on ties.
    always_comb begin
        id_o        = '0;
        any_valid_o = 1'b0;
        best        = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (valid_i[i] && (!any_valid_o || prio_i[i] > best)) begin
                any_valid_o = 1'b1;
                best        = prio_i[i];
                id_o        = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/apb_irq_controller_n.sv
// APB interrupt controller with NUM_IRQ sources, per-source edge/level mode,
// enable and priority, and an ID/ACK handshake to the core.
// Optional macro IRQ_CLK_GATE_EN adds clk_en_i, which freezes pending
// capture, edge history and the FSM while low (APB registers stay writable).
module apb_irq_controller_n
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int PRIO_W  = DEFAULT_PRIO_W,
    parameter int ID_W    = DEFAULT_ID_W
) (
    input  logic               pclk_i,
    input  logic               rst_n_i,
`ifdef IRQ_CLK_GATE_EN
    input  logic               clk_en_i,
`endif
    input  logic               psel_i,
    input  logic               penable_i,
    input  logic               pwrite_i,
    input  logic [31:0]        paddr_i,
    input  logic [31:0]        pwdata_i,
    output logic [31:0]        prdata_o,
    output logic               pready_o,
    output logic               pslverr_o,
    input  logic [NUM_IRQ-1:0] irq_trigger_i,
    output logic               irq_o,
    output logic [ID_W-1:0]    irq_id_o
);

    irq_state_e                     state;
    logic [NUM_IRQ-1:0]             enable, mode, pending, prev;
    logic [NUM_IRQ-1:0][PRIO_W-1:0] prio;
    logic                           global_en;
    logic                           tick;

`ifdef IRQ_CLK_GATE_EN
    assign tick = clk_en_i;
`else
    assign tick = 1'b1;
`endif

    logic [7:0]  addr, prio_off;
    logic        acc, wr_ok, addr_bad, ack_match, ack_hit, prio_hit;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign unused_bits = ^{paddr_i[31:8], pwdata_i};
    assign addr        = paddr_i[7:0];
    assign acc         = psel_i & penable_i;
    assign prio_off    = addr - REG_PRIO_BASE;
    assign prio_hit    = (addr >= REG_PRIO_BASE) && (prio_off < 8'(NUM_IRQ));
    assign ack_match   = (state == ST_SERVE) && (pwdata_i[ID_W-1:0] == irq_id_o);
    assign wr_ok       = acc & pwrite_i & ~addr_bad;
    // An ACK that lands while the logic is frozen is silently dropped.
    assign ack_hit     = wr_ok && (addr == REG_ACK) && ack_match && tick;

    // Read mux and address validity.
    always_comb begin
        rd_data  = '0;
        addr_bad = 1'b0;
        case (addr)
            REG_ENABLE:    rd_data = 32'(enable);
            REG_MODE:      rd_data = 32'(mode);
            REG_PENDING:   rd_data = 32'(pending);
            REG_ACTIVE:    rd_data = {state == ST_SERVE, 31'(irq_id_o)};
            REG_ACK:       rd_data = '0;
            REG_GLOBAL_EN: rd_data = {31'b0, global_en};
            default: begin
                if (prio_hit) begin
                    for (int i = 0; i < NUM_IRQ; i++)
                        if (prio_off == 8'(i)) rd_data = 32'(prio[i]);
                end else begin
                    addr_bad = 1'b1;
                end
            end
        endcase
    end

    assign pready_o  = 1'b1;
    assign prdata_o  = (acc && !pwrite_i && !addr_bad) ? rd_data : 32'b0;
    assign pslverr_o = acc && (addr_bad || (pwrite_i && addr == REG_ACK && !ack_match));

    logic [NUM_IRQ-1:0] mode_chg, rise, w1c, ack_clr, id_onehot, eligible, pend_nxt;
    logic [ID_W-1:0]    win_id;
    logic               any_valid;

    assign id_onehot = NUM_IRQ'(1) << irq_id_o;
    assign mode_chg  = (wr_ok && addr == REG_MODE) ? (mode ^ pwdata_i[NUM_IRQ-1:0]) : '0;
    assign w1c       = (wr_ok && addr == REG_PENDING) ? pwdata_i[NUM_IRQ-1:0] : '0;
    assign ack_clr   = ack_hit ? id_onehot : '0;
    // A bit whose mode is being rewritten cannot see an edge this cycle.
    assign rise      = irq_trigger_i & ~prev & ~mode_chg;
    // Edge bits: set beats any clear. Level bits: track the input.
    assign pend_nxt  = (mode & (rise | (pending & ~w1c & ~ack_clr))) | (~mode & irq_trigger_i);
    assign eligible  = pending & enable & {NUM_IRQ{global_en}};

    irq_prio_arbiter #(
        .NUM_IRQ (NUM_IRQ),
        .PRIO_W  (PRIO_W),
        .ID_W    (ID_W)
    ) u_arb (
        .valid_i     (eligible),
        .prio_i      (prio),
        .id_o        (win_id),
        .any_valid_o (any_valid)
    );

    // Configuration registers, always writable over APB.
    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            enable    <= '0;
            mode      <= '0;
            global_en <= 1'b0;
            prio      <= '0;
        end else if (wr_ok) begin
            if (addr == REG_ENABLE)    enable    <= pwdata_i[NUM_IRQ-1:0];
            if (addr == REG_MODE)      mode      <= pwdata_i[NUM_IRQ-1:0];
            if (addr == REG_GLOBAL_EN) global_en <= pwdata_i[0];
            for (int i = 0; i < NUM_IRQ; i++)
                if (prio_hit && prio_off == 8'(i)) prio[i] <= pwdata_i[PRIO_W-1:0];
        end
    end

    // Pending capture and edge history.
    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pending <= '0;
            prev    <= '0;
        end else if (tick) begin
            pending <= pend_nxt;
            prev    <= irq_trigger_i;
        end
    end

    // Serve FSM: latch winner, hold until ACK or loss of eligibility, then
    // force one low cycle after an ACK.
    always_ff @(posedge pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= ST_IDLE;
            irq_o    <= 1'b0;
            irq_id_o <= '0;
        end else if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (any_valid) begin
                        state    <= ST_SERVE;
                        irq_o    <= 1'b1;
                        irq_id_o <= win_id;
                    end
                end
                ST_SERVE: begin
                    if (ack_hit) begin
                        state <= ST_GAP;
                        irq_o <= 1'b0;
                    end else if (!(|(eligible & id_onehot))) begin
                        state <= ST_IDLE;
                        irq_o <= 1'b0;
                    end
                end
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
